// File: rtl/arb_pkg.sv
// Shared types and constants for the 32-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 32;
  localparam int unsigned IDX_W = 5;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] vec_t;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic idx_t first_set(vec_t v);
    idx_t r;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter32_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter32_if;

  arb_pkg::vec_t Req_in;
  logic          Release_in;
  logic          Grant_valid;
  arb_pkg::idx_t Grant_idx;
  arb_pkg::vec_t Grant_out;
  logic          Busy;
  logic          Timeout_pulse;

  modport master (
    output Req_in, Release_in,
    input  Grant_valid, Grant_idx, Grant_out, Busy, Timeout_pulse
  );

  modport slave (
    input  Req_in, Release_in,
    output Grant_valid, Grant_idx, Grant_out, Busy, Timeout_pulse
  );

endinterface

// File: rtl/grant_onehot_dec.sv
// Combinational 5-to-32 one-hot decoder for the next grant vector.
module grant_onehot_dec
  import arb_pkg::*;
(
  input  idx_t idx_i,
  output vec_t vec_o
);

  assign vec_o = vec_t'(1) << idx_i;

endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter for 32 requesters with registered index and one-hot grant.
// Optional hold timeout enabled by defining ARB_TIMEOUT_EN (length MAX_HOLD cycles).
module rr_arbiter32
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic           Clk,
  input logic           Rst_n,
  rr_arbiter32_if.slave arb_io
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end

  arb_state_t state_q, state_d;
  idx_t       ptr_q, ptr_d;
  logic       grant_valid_q, grant_valid_d;
  idx_t       grant_idx_q, grant_idx_d;
  vec_t       grant_out_q, grant_out_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  vec_t req_rot;
  idx_t winner;
  vec_t winner_vec;
  logic owner_done;

  // Rotate so bit 0 is the requester at ptr; the lowest set bit is then the winner.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_rot[i] = arb_io.Req_in[idx_t'(i) + ptr_q];
    end
  end

  assign winner     = first_set(req_rot) + ptr_q;
  assign owner_done = arb_io.Release_in || !arb_io.Req_in[grant_idx_q];

  grant_onehot_dec u_dec (
    .idx_i (winner),
    .vec_o (winner_vec)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    grant_out_d   = grant_out_q;
    busy_d        = busy_q;
    timeout_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|arb_io.Req_in) begin
          state_d       = GRANT;
          grant_valid_d = 1'b1;
          grant_idx_d   = winner;
          grant_out_d   = winner_vec;
          busy_d        = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d    = '0;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        if (owner_done || hold_cnt_q == HoldLast) begin
          // A real release wins over a coincident timeout.
          timeout_d = !owner_done;
`else
        if (owner_done) begin
`endif
          state_d       = IDLE;
          ptr_d         = grant_idx_q + idx_t'(1);
          grant_valid_d = 1'b0;
          grant_idx_d   = '0;
          grant_out_d   = '0;
          busy_d        = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      grant_out_q   <= '0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      grant_out_q   <= grant_out_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
`endif
    end
  end

  assign arb_io.Grant_valid   = grant_valid_q;
  assign arb_io.Grant_idx     = grant_idx_q;
  assign arb_io.Grant_out     = grant_out_q;
  assign arb_io.Busy          = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign arb_io.Timeout_pulse = timeout_q;
`else
  assign arb_io.Timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed self-checking bench for rr_arbiter32; timeout checks follow ARB_TIMEOUT_EN.
module tb_rr_arbiter32;

  localparam int unsigned TbHold = 4;

  logic Clk;
  logic Rst_n;
  int   n_checks;
  int   n_errors;

  rr_arbiter32_if arb_if ();

  rr_arbiter32 #(
    .MAX_HOLD (TbHold)
  ) u_dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .arb_io (arb_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  // Observe the bubble, then the next grant, after releasing the current owner.
  task automatic release_then_grant(input string tag, input logic [31:0] req, input int exp_idx);
    arb_if.Req_in     = req;
    arb_if.Release_in = 1'b1;
    tick();
    arb_if.Release_in = 1'b0;
    check({tag, "_bubble"}, 32'(arb_if.Grant_valid), 32'd0);
    tick();
    check({tag, "_idx"}, 32'(arb_if.Grant_idx), 32'(exp_idx));
    check({tag, "_out"}, arb_if.Grant_out, 32'd1 << exp_idx);
  endtask

  initial begin
    int held;
    int rot_seq [3];
    n_checks = 0;
    n_errors = 0;
    rot_seq  = '{31, 0, 31};

    // Reset with every requester active.
    Rst_n             = 1'b0;
    arb_if.Req_in     = 32'hFFFF_FFFF;
    arb_if.Release_in = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(arb_if.Grant_valid), 32'd0);
    check("rst_idx", 32'(arb_if.Grant_idx), 32'd0);
    check("rst_out", arb_if.Grant_out, 32'd0);
    check("rst_busy", 32'(arb_if.Busy), 32'd0);
    check("rst_tp", 32'(arb_if.Timeout_pulse), 32'd0);
    Rst_n = 1'b1;
    tick();
    check("first_idx", 32'(arb_if.Grant_idx), 32'd0);
    check("first_out", arb_if.Grant_out, 32'h1);
    check("first_busy", 32'(arb_if.Busy), 32'd1);

    // Two requesters at opposite ends alternate.
    for (int i = 0; i < 3; i++) begin
      release_then_grant("rot", 32'h8000_0001, rot_seq[i]);
    end

    // Grant 30 from ptr 0, then wrap from ptr 31 to requester 2.
    release_then_grant("to30", 32'h4000_0000, 30);
    release_then_grant("wrap", 32'h0000_0004, 2);

    // Request drop frees the grant and moves ptr to 6.
    release_then_grant("g5", 32'h0000_0020, 5);
    arb_if.Req_in = 32'h0;
    tick();
    check("drop_valid", 32'(arb_if.Grant_valid), 32'd0);
    check("drop_busy", 32'(arb_if.Busy), 32'd0);
    arb_if.Req_in = 32'h0000_0070;
    tick();
    check("drop_ptr6", 32'(arb_if.Grant_idx), 32'd6);

    // Asynchronous reset while requester 12 owns the resource.
    release_then_grant("g12", 32'h0000_1000, 12);
    #2 Rst_n = 1'b0;
    #1;
    check("async_valid", 32'(arb_if.Grant_valid), 32'd0);
    check("async_idx", 32'(arb_if.Grant_idx), 32'd0);
    check("async_out", arb_if.Grant_out, 32'd0);
    arb_if.Req_in = 32'h0010_0002;
    tick();
    Rst_n = 1'b1;
    tick();
    check("post_rst_ptr0", 32'(arb_if.Grant_idx), 32'd1);

    // Hold behaviour for a requester that never releases.
    release_then_grant("g7", 32'h0000_0080, 7);
    held = 0;
    while (arb_if.Grant_valid && held < 120) begin
      held++;
      tick();
    end
`ifdef ARB_TIMEOUT_EN
    check("hold_len", 32'(held), 32'(TbHold));
    check("tp_high", 32'(arb_if.Timeout_pulse), 32'd1);
    arb_if.Req_in = 32'h0000_0180;
    tick();
    check("tp_low", 32'(arb_if.Timeout_pulse), 32'd0);
    check("tmo_ptr8", 32'(arb_if.Grant_idx), 32'd8);
`else
    check("hold_forever", 32'(held), 32'd120);
    check("tp_tied", 32'(arb_if.Timeout_pulse), 32'd0);
    release_then_grant("after_hold", 32'h0000_0180, 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
